// File: rtl/char_timing_gen_if.sv
// Character-display raster bus: cell coordinates plus pipeline-aligned VGA sync/blank.
// Driven by char_timing_gen every cycle; no handshake, consumers sample every cycle.
interface char_timing_gen_if;
    logic [6:0] char_column;
    logic [6:0] char_line;
    logic [2:0] subchar_pixel;
    logic [2:0] subchar_line;
    logic       hsync;
    logic       vsync;
    logic       blank;
    logic       frame_start;

    modport master (
        output char_column, char_line, subchar_pixel, subchar_line,
        output hsync, vsync, blank, frame_start
    );

    modport slave (
        input char_column, char_line, subchar_pixel, subchar_line,
        input hsync, vsync, blank, frame_start
    );
endinterface

// File: rtl/char_timing_gen.sv
// Raster timing source: character-cell coordinates plus VGA hsync/vsync/blank/frame_start.
// Coordinates track the counters with no lag; sync path lags PIPE_DLY cycles; free-running, no backpressure.
module char_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int SYNC_POL = 0,
    parameter int PIPE_DLY = 2
) (
    input  logic               pixel_clock,
    input  logic               reset,
    char_timing_gen_if.master  disp
);

    localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

    if (H_TOT > 1023 || V_TOT > 1023) begin : g_tot_chk
        $error("char_timing_gen: line or frame total exceeds 10-bit counter range");
    end
    if (PIPE_DLY < 1 || PIPE_DLY > 7) begin : g_dly_chk
        $error("char_timing_gen: PIPE_DLY must be within 1..7");
    end

    localparam logic [9:0] H_LAST   = 10'(H_TOT - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOT - 1);
    localparam logic [9:0] H_ACT_C  = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT_C  = 10'(V_ACTIVE);
    localparam logic [9:0] HS_BEG   = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_BEG   = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic       POL      = (SYNC_POL != 0);

    typedef struct packed {
        logic hs;
        logic vs;
        logic bl;
        logic fs;
    } sync_t;

    localparam sync_t SYNC_IDLE = '{hs: 1'b0, vs: 1'b0, bl: 1'b1, fs: 1'b0};

    logic [9:0] h_cnt, v_cnt;
    logic [9:0] h_nxt, v_nxt;
    logic [6:0] col_q, line_q;
    logic [2:0] spix_q, sline_q;
    sync_t      sync_raw;
    sync_t      stage [PIPE_DLY];

    always_comb begin
        h_nxt = (h_cnt == H_LAST) ? 10'd0 : h_cnt + 10'd1;
        v_nxt = v_cnt;
        if (h_cnt == H_LAST) begin
            v_nxt = (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;
        end
    end

    // Coordinates are computed from the next count so they land in the same cycle as the count.
    always_ff @(posedge pixel_clock or posedge reset) begin
        if (reset) begin
            h_cnt   <= '0;
            v_cnt   <= '0;
            col_q   <= '0;
            spix_q  <= '0;
            line_q  <= '0;
            sline_q <= '0;
        end else begin
            h_cnt <= h_nxt;
            v_cnt <= v_nxt;
            if (h_nxt < H_ACT_C) begin
                col_q  <= h_nxt[9:3];
                spix_q <= h_nxt[2:0];
            end else begin
                col_q  <= '0;
                spix_q <= '0;
            end
            if (v_nxt < V_ACT_C) begin
                line_q  <= v_nxt[9:3];
                sline_q <= v_nxt[2:0];
            end else begin
                line_q  <= '0;
                sline_q <= '0;
            end
        end
    end

    always_comb begin
        sync_raw    = SYNC_IDLE;
        sync_raw.hs = (h_cnt >= HS_BEG) && (h_cnt < HS_END);
        sync_raw.vs = (v_cnt >= VS_BEG) && (v_cnt < VS_END);
        sync_raw.bl = !((h_cnt < H_ACT_C) && (v_cnt < V_ACT_C));
        sync_raw.fs = (h_cnt == 10'd0) && (v_cnt == 10'd0);
    end

    // Stage 0 registers the raw decode; PIPE_DLY stages in total match the pixel pipeline.
    always_ff @(posedge pixel_clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < PIPE_DLY; i++) begin
                stage[i] <= SYNC_IDLE;
            end
        end else begin
            stage[0] <= sync_raw;
            for (int i = 1; i < PIPE_DLY; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign disp.char_column   = col_q;
    assign disp.subchar_pixel = spix_q;
    assign disp.char_line     = line_q;
    assign disp.subchar_line  = sline_q;
    assign disp.hsync         = stage[PIPE_DLY-1].hs ~^ POL;
    assign disp.vsync         = stage[PIPE_DLY-1].vs ~^ POL;
    assign disp.blank         = stage[PIPE_DLY-1].bl;
    assign disp.frame_start   = stage[PIPE_DLY-1].fs;

endmodule

// File: tb/tb_char_timing_gen.sv
// Bench for char_timing_gen: one full-size head plus three reduced-timing heads
// (PIPE_DLY 2/1/5, one with active-high sync) checked every cycle against an arithmetic raster model.
module tb_char_timing_gen;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [6:0] col;
        logic [6:0] line;
        logic [2:0] spix;
        logic [2:0] sline;
        logic       hs;
        logic       vs;
        logic       bl;
        logic       fs;
    } obs_t;

    char_timing_gen_if i_def ();
    char_timing_gen_if i_s2 ();
    char_timing_gen_if i_s1 ();
    char_timing_gen_if i_s5 ();

    char_timing_gen u_def (.pixel_clock(clk), .reset(reset), .disp(i_def));
    char_timing_gen #(.H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3), .V_ACTIVE(16), .V_FP(2),
                      .V_SYNC(2), .V_BP(3), .SYNC_POL(0), .PIPE_DLY(2))
        u_s2 (.pixel_clock(clk), .reset(reset), .disp(i_s2));
    char_timing_gen #(.H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3), .V_ACTIVE(16), .V_FP(2),
                      .V_SYNC(2), .V_BP(3), .SYNC_POL(0), .PIPE_DLY(1))
        u_s1 (.pixel_clock(clk), .reset(reset), .disp(i_s1));
    char_timing_gen #(.H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3), .V_ACTIVE(16), .V_FP(2),
                      .V_SYNC(2), .V_BP(3), .SYNC_POL(1), .PIPE_DLY(5))
        u_s5 (.pixel_clock(clk), .reset(reset), .disp(i_s5));

    obs_t o_def, o_s2, o_s1, o_s5;
    assign o_def = '{i_def.char_column, i_def.char_line, i_def.subchar_pixel, i_def.subchar_line,
                     i_def.hsync, i_def.vsync, i_def.blank, i_def.frame_start};
    assign o_s2  = '{i_s2.char_column, i_s2.char_line, i_s2.subchar_pixel, i_s2.subchar_line,
                     i_s2.hsync, i_s2.vsync, i_s2.blank, i_s2.frame_start};
    assign o_s1  = '{i_s1.char_column, i_s1.char_line, i_s1.subchar_pixel, i_s1.subchar_line,
                     i_s1.hsync, i_s1.vsync, i_s1.blank, i_s1.frame_start};
    assign o_s5  = '{i_s5.char_column, i_s5.char_line, i_s5.subchar_pixel, i_s5.subchar_line,
                     i_s5.hsync, i_s5.vsync, i_s5.blank, i_s5.frame_start};

    int n_tot  = 0;
    int n_pass = 0;
    int cyc    = 0;

    // Raster position is a pure function of cycles since reset release.
    function automatic obs_t model(int c, int ha, int hf, int hsw, int hb,
                                   int va, int vf, int vsw, int vb, int pol, int d);
        obs_t r;
        int ht, vt, h, v, e, he, ve;
        ht = ha + hf + hsw + hb;
        vt = va + vf + vsw + vb;
        h  = c % ht;
        v  = (c / ht) % vt;
        r.col   = (h < ha) ? 7'(h / 8) : 7'd0;
        r.spix  = (h < ha) ? 3'(h % 8) : 3'd0;
        r.line  = (v < va) ? 7'(v / 8) : 7'd0;
        r.sline = (v < va) ? 3'(v % 8) : 3'd0;
        r.hs = (pol == 0);
        r.vs = (pol == 0);
        r.bl = 1'b1;
        r.fs = 1'b0;
        if (c >= d) begin
            e  = c - d;
            he = e % ht;
            ve = (e / ht) % vt;
            r.hs = ((he >= ha + hf) && (he < ha + hf + hsw)) ? (pol != 0) : (pol == 0);
            r.vs = ((ve >= va + vf) && (ve < va + vf + vsw)) ? (pol != 0) : (pol == 0);
            r.bl = !((he < ha) && (ve < va));
            r.fs = ((e % (ht * vt)) == 0);
        end
        return r;
    endfunction

    function automatic obs_t rst_val(int pol);
        obs_t r;
        r = '0;
        r.hs = (pol == 0);
        r.vs = (pol == 0);
        r.bl = 1'b1;
        return r;
    endfunction

    task automatic check(string nm, int c, obs_t got, obs_t exp);
        n_tot++;
        if (got === exp) n_pass++;
        else $display("FAIL %s c=%0d got col=%0d line=%0d spix=%0d sline=%0d hs=%0b vs=%0b bl=%0b fs=%0b want col=%0d line=%0d spix=%0d sline=%0d hs=%0b vs=%0b bl=%0b fs=%0b",
                      nm, c, got.col, got.line, got.spix, got.sline, got.hs, got.vs, got.bl, got.fs,
                      exp.col, exp.line, exp.spix, exp.sline, exp.hs, exp.vs, exp.bl, exp.fs);
    endtask

    task automatic lit(string nm, int got, int exp);
        n_tot++;
        if (got == exp) n_pass++;
        else $display("FAIL %s got=%0d want=%0d", nm, got, exp);
    endtask

    int last_fs2 = -1;
    int last_fs5 = -1;
    int hs_low   = 0;
    int vs_low   = 0;

    always @(negedge clk) begin
        if (reset) begin
            cyc = 0;
            last_fs2 = -1;
            last_fs5 = -1;
            hs_low = 0;
            vs_low = 0;
        end else begin
            check("def", cyc, o_def, model(cyc, 640, 16, 96, 48, 480, 10, 2, 33, 0, 2));
            check("s2",  cyc, o_s2,  model(cyc, 16, 2, 3, 3, 16, 2, 2, 3, 0, 2));
            check("s1",  cyc, o_s1,  model(cyc, 16, 2, 3, 3, 16, 2, 2, 3, 0, 1));
            check("s5",  cyc, o_s5,  model(cyc, 16, 2, 3, 3, 16, 2, 2, 3, 1, 5));

            if (cyc < 800 && !o_def.hs) hs_low++;
            if (cyc < 552 && !o_s2.vs) vs_low++;
            case (cyc)
                2:    begin lit("fs_first_def", o_def.fs, 1); lit("fs_first_s2", o_s2.fs, 1); end
                7:    begin lit("col_h7", o_def.col, 0); lit("spix_h7", o_def.spix, 7); end
                8:    begin lit("col_h8", o_def.col, 1); lit("spix_h8", o_def.spix, 0); end
                16:   lit("s1_blank_pre", o_s1.bl, 0);
                17:   lit("s1_blank_rise", o_s1.bl, 1);
                20:   lit("s5_blank_pre", o_s5.bl, 0);
                21:   lit("s5_blank_rise", o_s5.bl, 1);
                360:  begin lit("line_v15", o_s2.line, 1); lit("sline_v15", o_s2.sline, 7); end
                384:  begin lit("line_v16", o_s2.line, 0); lit("sline_v16", o_s2.sline, 0); end
                432:  lit("s1_vs_pre", o_s1.vs, 1);
                433:  begin lit("s1_vs_start", o_s1.vs, 0); lit("s2_vs_pre", o_s2.vs, 1); end
                434:  lit("s2_vs_start", o_s2.vs, 0);
                436:  lit("s5_vs_pre", o_s5.vs, 0);
                437:  lit("s5_vs_start", o_s5.vs, 1);
                551:  lit("s2_vs_low_len", vs_low, 48);
                639:  begin lit("col_h639", o_def.col, 79); lit("spix_h639", o_def.spix, 7); end
                640:  begin lit("col_h640", o_def.col, 0); lit("spix_h640", o_def.spix, 0); end
                641:  lit("blank_pre", o_def.bl, 0);
                642:  lit("blank_rise", o_def.bl, 1);
                657:  lit("hs_pre", o_def.hs, 1);
                658:  lit("hs_start", o_def.hs, 0);
                753:  lit("hs_last", o_def.hs, 0);
                754:  lit("hs_end", o_def.hs, 1);
                799:  lit("hs_low_len", hs_low, 96);
                1458: lit("hs_line1_start", o_def.hs, 0);
                default: ;
            endcase

            if (o_s2.fs) begin
                lit("s2_fs_blank", o_s2.bl, 0);
                if (last_fs2 >= 0) lit("s2_fs_period", cyc - last_fs2, 552);
                last_fs2 = cyc;
            end
            if (o_s5.fs) begin
                if (last_fs5 >= 0) lit("s5_fs_period", cyc - last_fs5, 552);
                last_fs5 = cyc;
            end
            cyc++;
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        #2;
        check("rst_def", -1, o_def, rst_val(0));
        check("rst_s2",  -1, o_s2,  rst_val(0));
        check("rst_s1",  -1, o_s1,  rst_val(0));
        check("rst_s5",  -1, o_s5,  rst_val(1));

        @(posedge clk);
        #1 reset = 1'b0;
        // Reset lands two cycles after a frame start, while the PIPE_DLY=5 pulse is still in flight.
        repeat (1658) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        check("arst_def", -2, o_def, rst_val(0));
        check("arst_s2",  -2, o_s2,  rst_val(0));
        check("arst_s1",  -2, o_s1,  rst_val(0));
        check("arst_s5",  -2, o_s5,  rst_val(1));

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        repeat (700) @(posedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
